app_mult_signed_pipe: RTL and testbench
=======================================

APP_MULT_SIGNED_PIPE -- requirements
Module: app_mult_signed_pipe

Interface
REQ-001 SHALL have parameter WA, default 16, meaning operand A width in bits (legal 4..32).
REQ-002 SHALL have parameter WB, default 16, meaning operand B width in bits (legal 4..32).
REQ-003 SHALL have parameter STAGES, default 3, meaning pipeline depth in register stages (legal 2..4).
REQ-004 SHALL have parameter ACC_W, default WA+WB+8, meaning accumulator width (used only when APP_MULT_ACC_EN is defined).
REQ-005 SHALL have port sys_clk  in  1  meaning the single clock; all flops rise-edge.
REQ-006 SHALL have port sys_rst  in  1  meaning asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  in  1  meaning operands a/b are presented.
REQ-008 SHALL have port in_ready  out  1  meaning the block accepts this cycle.
REQ-009 SHALL have port a  in  WA  meaning the signed two's-complement multiplicand.
REQ-010 SHALL have port b  in  WB  meaning the signed two's-complement multiplier.
REQ-011 SHALL have port acc_clr  in  1  meaning restart the accumulation, sampled with the accepted operand (present only with APP_MULT_ACC_EN).
REQ-012 SHALL have port out_valid  out  1  meaning result is valid.
REQ-013 SHALL have port out_ready  in  1  meaning downstream accepts result.
REQ-014 SHALL have port result  out  RW  meaning signed output; RW = WA+WB without the macro and ACC_W with it.
REQ-015 SHALL have port sat  out  1  meaning the accumulator clamped on this result (present only with APP_MULT_ACC_EN).

Function
REQ-016 SHALL accept an operand pair only on a cycle with in_valid && in_ready.
REQ-017 SHALL compute the exact signed product a*b in WA+WB bits, with no approximation or truncation.
REQ-018 SHALL have pipeline advance enable adv = !out_valid || out_ready, and in_ready SHALL equal adv (combinational).
REQ-019 SHALL have a latency of exactly STAGES cycles from acceptance to out_valid when adv stays high; each stall cycle adds one cycle.
REQ-020 SHALL hold every stage, including result/out_valid, stable while adv is low, with no data loss or duplication.
REQ-021 SHALL carry a bubble (valid=0) through a stage when in_valid is low on an advancing cycle.
REQ-022 SHALL emit results in acceptance order; one result per accepted pair.
REQ-023 SHALL sustain throughput of one pair per cycle while out_ready is held high.
REQ-024 SHALL keep result at its last value when out_valid is low; its contents carry no meaning.

Reset
REQ-025 SHALL, while sys_rst is high, clear all stage valid bits, drive out_valid=0, result=0 and sat=0, and zero the accumulator.
REQ-026 SHALL discard in-flight operands on reset mid-operation; the first result after reset SHALL come from the first pair accepted after reset.
REQ-027 SHALL drive in_ready high during reset (out_valid=0), while ignoring in_valid until sys_rst deasserts.

Configuration
REQ-028 SHALL, with macro APP_MULT_ACC_EN defined, in the last stage compute acc_next = (acc_clr_of_that_item ? 0 : acc) + sign-extended product, clamp it to the signed ACC_W range, and output it as result with sat=1 iff a clamp occurred.
REQ-029 SHALL update the accumulator only when a valid item leaves the last stage; with acc_clr on that item, result SHALL equal that item's product.
REQ-030 SHALL, without APP_MULT_ACC_EN, omit acc_clr, sat and all accumulator logic, making result the product.

Structure
REQ-031 SHALL place in package app_mult_pkg the width functions (product width, accumulator width), the signed saturation min/max constant functions, and the stage-count legality check.
REQ-032 SHALL generate radix-4 Booth partial-product rows in a sub-module app_booth_row (one instance per B digit pair), reduced by a compressor tree and a final adder split across the STAGES registers.

Verification
REQ-033 SHALL cover: WA=WB=16, STAGES=3, out_ready=1, a=-32768, b=-32768 -> result=0x40000000, out_valid exactly 3 cycles after acceptance.
REQ-034 SHALL cover: back-to-back pairs (3,-5),(-7,-9),(32767,2) -> results -15, 63, 65534 on consecutive cycles.
REQ-035 SHALL cover: out_ready held low for 4 cycles with the pipeline full -> in_ready=0 during the stall, result stable, no loss, order preserved after release.
REQ-036 SHALL cover: sys_rst pulsed with 2 items in flight -> out_valid=0 immediately, the next result comes from the post-reset pair (100*100=10000).
REQ-037 SHALL cover, with APP_MULT_ACC_EN and ACC_W=20: acc_clr=1 with (1000,500), then (1000,500) -> result 500000, then 524287 with sat=1; a following acc_clr=1 with (2,3) -> result 6, sat=0.
REQ-038 SHALL cover: randomized a/b/in_valid/out_ready for 10000 pairs -> every output matches the reference model a*b, in order.

Source files
------------

// File: rtl/app_mult_pkg.sv
// Shared width helpers, saturation limits and parameter legality checks
// for the signed Booth multiplier pipeline.
package app_mult_pkg;

  // Width of the exact signed product.
  function automatic int prod_w(input int wa, input int wb);
    return wa + wb;
  endfunction

  // Default accumulator width: product plus eight guard bits.
  function automatic int acc_w(input int wa, input int wb);
    return wa + wb + 8;
  endfunction

  // Number of radix-4 Booth digits needed for a signed multiplier of wb bits.
  function automatic int booth_digits(input int wb);
    return (wb + 1) / 2;
  endfunction

  function automatic int max_w(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Largest value representable in a w-bit signed number.
  function automatic logic signed [127:0] sat_max(input int w);
    return (128'sd1 <<< (w - 1)) - 128'sd1;
  endfunction

  // Smallest value representable in a w-bit signed number.
  function automatic logic signed [127:0] sat_min(input int w);
    return -(128'sd1 <<< (w - 1));
  endfunction

  function automatic bit stages_legal(input int s);
    return (s >= 2) && (s <= 4);
  endfunction

endpackage

// File: rtl/app_booth_row.sv
// One radix-4 Booth partial-product row: selects 0, +/-a or +/-2a from a
// three-bit multiplier window and places it at its digit weight.
module app_booth_row #(
  parameter int WA    = 16,
  parameter int PW    = 32,
  parameter int SHIFT = 0
) (
  input  logic [WA-1:0] a,
  input  logic [2:0]    sel,
  output logic [PW-1:0] pp
);

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] mag;
  logic                 neg;

  assign a_ext = PW'($signed(a));

  // Decode the Booth window into a signed multiple of a.
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (sel)
      3'b001, 3'b010: mag = a_ext;
      3'b011:         mag = a_ext <<< 1;
      3'b100: begin
        mag = a_ext <<< 1;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = a_ext;
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    pp = (neg ? -mag : mag) << SHIFT;
  end

endmodule

// File: rtl/app_mult_signed_pipe.sv
// Pipelined signed multiplier with valid/ready handshake.
// Stage 1 holds the carry-save pair from the Booth array, stage 2 (when
// present) resolves it with the final adder, later stages delay, and the
// output register holds the result.
// Optional feature: define APP_MULT_ACC_EN for a saturating accumulator in
// the output stage (adds acc_clr and sat ports).
module app_mult_signed_pipe
  import app_mult_pkg::*;
#(
  parameter int WA     = 16,
  parameter int WB     = 16,
  parameter int STAGES = 3,
  parameter int ACC_W  = acc_w(WA, WB),
`ifdef APP_MULT_ACC_EN
  localparam bit ACC_EN = 1'b1,
`else
  localparam bit ACC_EN = 1'b0,
`endif
  localparam int RW = ACC_EN ? ACC_W : prod_w(WA, WB)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
`ifdef APP_MULT_ACC_EN
  input  logic          acc_clr,
  output logic          sat,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] result
);

  localparam int PW = prod_w(WA, WB);
  localparam int ND = booth_digits(WB);
  localparam int NS = STAGES - 1;

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("app_mult_signed_pipe: STAGES must be within 2..4");
  end

  logic adv;
  logic out_valid_q, out_valid_d;
  logic [RW-1:0] result_q, result_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Booth windows over b, sign-extended to an even width with an implicit 0 below bit 0.
  logic [2*ND-1:0] b_ext;
  logic [2*ND:0]   b_win;
  logic [PW-1:0]   pp [ND];

  assign b_ext = (2*ND)'($signed(b));
  assign b_win = {b_ext, 1'b0};

  for (genvar i = 0; i < ND; i++) begin : g_row
    app_booth_row #(
      .WA   (WA),
      .PW   (PW),
      .SHIFT(2 * i)
    ) u_row (
      .a  (a),
      .sel(b_win[2*i+2 -: 3]),
      .pp (pp[i])
    );
  end

  logic [PW-1:0] cs_sum, cs_car, maj;

  // Carry-save reduction of all Booth rows down to a sum/carry pair.
  always_comb begin
    cs_sum = pp[0];
    cs_car = pp[1];
    maj    = '0;
    for (int i = 2; i < ND; i++) begin
      maj    = (cs_sum & cs_car) | (cs_sum & pp[i]) | (cs_car & pp[i]);
      cs_sum = cs_sum ^ cs_car ^ pp[i];
      cs_car = maj << 1;
    end
  end

  logic          vld_q [1:NS];
  logic          vld_d [1:NS];
  logic [PW-1:0] sum_q [1:NS];
  logic [PW-1:0] sum_d [1:NS];
  logic [PW-1:0] car_q [1:NS];
  logic [PW-1:0] car_d [1:NS];
`ifdef APP_MULT_ACC_EN
  logic          clr_q [1:NS];
  logic          clr_d [1:NS];
`endif

  // Advance the internal stages together; stage 2 performs the final add.
  always_comb begin
    for (int k = 1; k <= NS; k++) begin
      vld_d[k] = vld_q[k];
      sum_d[k] = sum_q[k];
      car_d[k] = car_q[k];
`ifdef APP_MULT_ACC_EN
      clr_d[k] = clr_q[k];
`endif
    end
    if (adv) begin
      vld_d[1] = in_valid;
      if (in_valid) begin
        sum_d[1] = cs_sum;
        car_d[1] = cs_car;
`ifdef APP_MULT_ACC_EN
        clr_d[1] = acc_clr;
`endif
      end
      for (int k = 2; k <= NS; k++) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          if (k == 2) begin
            sum_d[k] = sum_q[k-1] + car_q[k-1];
            car_d[k] = '0;
          end else begin
            sum_d[k] = sum_q[k-1];
            car_d[k] = car_q[k-1];
          end
`ifdef APP_MULT_ACC_EN
          clr_d[k] = clr_q[k-1];
`endif
        end
      end
    end
  end

  logic [PW-1:0] prod;
  assign prod = sum_q[NS] + car_q[NS];

`ifdef APP_MULT_ACC_EN
  // The output register doubles as the accumulator: it always holds the last
  // clamped running sum.
  localparam int SW = max_w(PW, ACC_W) + 1;
  localparam logic signed [SW-1:0] SMAX = SW'(sat_max(ACC_W));
  localparam logic signed [SW-1:0] SMIN = SW'(sat_min(ACC_W));

  logic sat_q, sat_d;
  logic signed [SW-1:0] acc_base, acc_sum;

  assign acc_base = clr_q[NS] ? '0 : SW'($signed(result_q));
  assign acc_sum  = acc_base + SW'($signed(prod));
  assign sat      = sat_q;
`endif

  // Output stage: load a new result only when a valid item leaves the pipe.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
`ifdef APP_MULT_ACC_EN
    sat_d       = sat_q;
`endif
    if (adv) begin
      out_valid_d = vld_q[NS];
      if (vld_q[NS]) begin
`ifdef APP_MULT_ACC_EN
        if (acc_sum > SMAX) begin
          result_d = ACC_W'(SMAX);
          sat_d    = 1'b1;
        end else if (acc_sum < SMIN) begin
          result_d = ACC_W'(SMIN);
          sat_d    = 1'b1;
        end else begin
          result_d = ACC_W'(acc_sum);
          sat_d    = 1'b0;
        end
`else
        result_d = prod;
`endif
      end
    end
  end

  // All pipeline state; reset discards everything in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int k = 1; k <= NS; k++) begin
        vld_q[k] <= 1'b0;
        sum_q[k] <= '0;
        car_q[k] <= '0;
`ifdef APP_MULT_ACC_EN
        clr_q[k] <= 1'b0;
`endif
      end
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef APP_MULT_ACC_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      for (int k = 1; k <= NS; k++) begin
        vld_q[k] <= vld_d[k];
        sum_q[k] <= sum_d[k];
        car_q[k] <= car_d[k];
`ifdef APP_MULT_ACC_EN
        clr_q[k] <= clr_d[k];
`endif
      end
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
`ifdef APP_MULT_ACC_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_app_mult_signed_pipe.sv
// Directed and randomized checks for app_mult_signed_pipe (WA=WB=16, STAGES=3).
module tb_app_mult_signed_pipe;

`ifdef APP_MULT_ACC_EN
  localparam int RW = 20;
`else
  localparam int RW = 32;
`endif

  logic          sys_clk, sys_rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [15:0]   a, b;
  logic [RW-1:0] result;
`ifdef APP_MULT_ACC_EN
  logic          acc_clr, sat;
`endif

  int checks = 0;
  int errors = 0;

  app_mult_signed_pipe #(
    .WA(16),
    .WB(16),
`ifdef APP_MULT_ACC_EN
    .ACC_W(20),
`endif
    .STAGES(3)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
`ifdef APP_MULT_ACC_EN
    .acc_clr  (acc_clr),
    .sat      (sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst   = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'd3;
    b = 16'd3;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef APP_MULT_ACC_EN
    checks++;
    if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sat); end
`endif
    in_valid = 1'b0;
    sys_rst  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ignored_input got out_valid %b want 0", out_valid); end
  endtask

`ifndef APP_MULT_ACC_EN
  task automatic test_min_corner();
    int n;
    out_ready = 1'b1;
    a = 16'h8000;
    b = 16'h8000;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL corner_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL corner_latency got %0d want 3", n); end
    checks++;
    if (result !== 32'h4000_0000) begin errors++; $display("FAIL corner_result got %h want 40000000", result); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL corner_single got out_valid %b want 0", out_valid); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [RW-1:0] e [3];
    e[0] = RW'(-15);
    e[1] = RW'(63);
    e[2] = RW'(65534);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 16'd3;     b = 16'(-5); tick();
    a = 16'(-7);   b = 16'(-9); tick();
    a = 16'd32767; b = 16'd2;   tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== e[i])
        begin errors++; $display("FAIL b2b_%0d got v=%b r=%h want v=1 r=%h", i, out_valid, result, e[i]); end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    logic [15:0]   pa [6];
    logic [15:0]   pb [6];
    logic [RW-1:0] pe [6];
    int idx_in, idx_out, cyc;
    pa = '{16'd10, 16'd20, 16'(-4), 16'd7, 16'(-1), 16'd12};
    pb = '{16'd10, 16'(-3), 16'd25, 16'd7, 16'(-1), 16'(-12)};
    pe = '{RW'(100), RW'(-60), RW'(-100), RW'(49), RW'(1), RW'(-144)};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = pa[i];
      b = pb[i];
      tick();
    end
    out_ready = 1'b0;
    a = pa[3];
    b = pb[3];
    repeat (4) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || result !== pe[0])
        begin errors++; $display("FAIL stall_hold got v=%b r=%h want v=1 r=%h", out_valid, result, pe[0]); end
      tick();
    end
    idx_in  = 3;
    idx_out = 0;
    cyc     = 0;
    while (idx_out < 6 && cyc < 30) begin
      out_ready = 1'b1;
      in_valid  = (idx_in < 6);
      if (idx_in < 6) begin
        a = pa[idx_in];
        b = pb[idx_in];
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (result !== pe[idx_out])
          begin errors++; $display("FAIL stall_order_%0d got %h want %h", idx_out, result, pe[idx_out]); end
        idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx_out != 6) begin errors++; $display("FAIL stall_drain got %0d results want 6", idx_out); end
  endtask

  task automatic test_reset_midflight();
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 16'd5; b = 16'd6; tick();
    a = 16'd7; b = 16'd8; tick();
    a = 16'd9; b = 16'd9;
    sys_rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL rst_mid_result got %h want 0", result); end
    tick();
    tick();
    sys_rst = 1'b0;
    a = 16'd100;
    b = 16'd100;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 3 || result !== RW'(10000))
      begin errors++; $display("FAIL rst_mid_first got n=%0d r=%h want n=3 r=%h", n, result, RW'(10000)); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_extra got out_valid %b want 0", out_valid); end
  endtask

`ifdef APP_MULT_ACC_EN
  task automatic test_acc();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    acc_clr = 1'b1; a = 16'd1000; b = 16'd500; tick();
    acc_clr = 1'b0; a = 16'd1000; b = 16'd500; tick();
    acc_clr = 1'b1; a = 16'd2;    b = 16'd3;   tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 20'd500000 || sat !== 1'b0)
      begin errors++; $display("FAIL acc_first got v=%b r=%0d s=%b want 1 500000 0", out_valid, result, sat); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || result !== 20'd524287 || sat !== 1'b1)
      begin errors++; $display("FAIL acc_clamp got v=%b r=%0d s=%b want 1 524287 1", out_valid, result, sat); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || result !== 20'd6 || sat !== 1'b0)
      begin errors++; $display("FAIL acc_restart got v=%b r=%0d s=%b want 1 6 0", out_valid, result, sat); end
    tick();
  endtask
`endif

`ifndef APP_MULT_ACC_EN
  task automatic test_random();
    logic signed [31:0] q [$];
    logic signed [31:0] e;
    logic signed [31:0] p;
    int sent, got, cyc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 10000 && cyc < 80000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra got %h want no result", result);
        end else begin
          e = q.pop_front();
          if (result !== e) begin errors++; $display("FAIL rand_%0d got %h want %h", got, result, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        p = $signed(a) * $signed(b);
        q.push_back(p);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 10000 || q.size() != 0)
      begin errors++; $display("FAIL rand_count got %0d results (%0d pending) want 10000", got, q.size()); end
  endtask
`endif

  initial begin
    sys_rst   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
`ifdef APP_MULT_ACC_EN
    acc_clr = 1'b1;
`endif
    test_reset();
`ifndef APP_MULT_ACC_EN
    test_min_corner();
`endif
    test_back_to_back();
    test_stall();
    test_reset_midflight();
`ifdef APP_MULT_ACC_EN
    test_acc();
`else
    test_random();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
